// File: rtl/pio_key_debounced_in_if.sv
// Avalon-MM style s1 slave bundle for the debounced key PIO.
// The master drives the address/strobe/write data; the slave returns
// registered read data and the level interrupt.
interface pio_key_debounced_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_key_debounced_in.sv
// Debounced key/button input PIO.
// Each input bit passes through a synchroniser and then a debounce filter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive differing
// samples. Accepted level changes can be qualified per bit (rising, falling,
// any, off) into a sticky write-1-to-clear edge-capture register, which,
// combined with a per-bit mask, drives a level interrupt.
module pio_key_debounced_in #(
    parameter int unsigned      WIDTH           = 2,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_port,
    pio_key_debounced_in_if.slave   s1
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_RAW       = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPT = 3'd3;
    localparam logic [2:0] ADDR_EDGE_MODE = 3'd4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_RISING  = 2'b01,
        MODE_FALLING = 2'b10,
        MODE_ANY     = 2'b11
    } edge_mode_e;

    logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_db;
    logic [CNT_W-1:0]   r_cnt [WIDTH];
    logic [WIDTH-1:0]   r_irq_mask;
    logic [2*WIDTH-1:0] r_edge_mode;
    logic [WIDTH-1:0]   r_edge_capture;
    logic [31:0]        r_readdata;

    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_upd;
    logic [WIDTH-1:0]   w_hit;
    logic [WIDTH-1:0]   w_w1c;
    logic               w_wr;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wdata;

    assign w_s            = r_sync[SYNC_STAGES-1];
    assign w_wr           = s1.chipselect && !s1.write_n;
    assign w_unused_wdata = ^s1.writedata;

    // Synchroniser chain: bring the asynchronous keys into the clock domain.
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // the sensitivity list holds only the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_LEVEL;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Per-bit accept strobe: the synchronised level has differed for the full window.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed path infers a latch.
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_upd[i] = (w_s[i] != r_db[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    // Debounce filter: count consecutive differing samples, restart on any bounce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_db[i]  <= w_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge qualification of each accepted level change against its mode.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (edge_mode_e'(r_edge_mode[2*i +: 2]))
                MODE_RISING:  w_hit[i] = w_upd[i] &&  w_s[i];
                MODE_FALLING: w_hit[i] = w_upd[i] && !w_s[i];
                MODE_ANY:     w_hit[i] = w_upd[i];
                default:      w_hit[i] = 1'b0;
            endcase
        end
    end

    assign w_w1c = (w_wr && s1.address == ADDR_EDGE_CAPT) ? s1.writedata[WIDTH-1:0] : '0;

    // Control registers and the sticky edge capture (a new hit wins over W1C).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_mask     <= '0;
            r_edge_mode    <= '0;
            r_edge_capture <= '0;
        end else begin
            if (w_wr && s1.address == ADDR_IRQ_MASK) begin
                r_irq_mask <= s1.writedata[WIDTH-1:0];
            end
            if (w_wr && s1.address == ADDR_EDGE_MODE) begin
                r_edge_mode <= s1.writedata[2*WIDTH-1:0];
            end
            r_edge_capture <= (r_edge_capture & ~w_w1c) | w_hit;
        end
    end

    // Read mux over the register map; unused words and upper bits read zero.
    always_comb begin
        w_rd_mux = '0;
        unique case (s1.address)
            ADDR_DATA:      w_rd_mux = 32'(r_db);
            ADDR_RAW:       w_rd_mux = 32'(w_s);
            ADDR_IRQ_MASK:  w_rd_mux = 32'(r_irq_mask);
            ADDR_EDGE_CAPT: w_rd_mux = 32'(r_edge_capture);
            ADDR_EDGE_MODE: w_rd_mux = 32'(r_edge_mode);
            default:        w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign s1.readdata = r_readdata;
    assign s1.irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_pio_key_debounced_in.sv
// Self-checking bench for the debounced key PIO: directed scenarios for the
// documented corner cases, then randomised traffic, all compared against a
// sliding-window behavioural model of the block.
module tb_pio_key_debounced_in;

    localparam int W  = 2;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;

    pio_key_debounced_in_if bus ();

    pio_key_debounced_in #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .RESET_LEVEL     (2'b11)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s1      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Behavioural model: the raw input delayed SS samples, a window of the
    // last DC synchronised samples per bit, and plain register contents.
    logic [W-1:0]   m_sync [SS];
    logic [DC-1:0]  m_win  [W];
    logic [W-1:0]   m_db, m_mask, m_ec;
    logic [2*W-1:0] m_mode;
    logic [31:0]    m_rd;
    logic           m_irq;

    task automatic model_edge(input logic rst, input logic [W-1:0] pin, input logic [2:0] addr,
                              input logic cs, input logic wn, input logic [31:0] wd);
        logic [W-1:0] s, hit, w1c;
        logic [1:0]   md;
        s   = m_sync[SS-1];
        hit = '0;
        w1c = '0;
        if (rst) begin
            for (int k = 0; k < SS; k++) m_sync[k] = 2'b11;
            for (int i = 0; i < W; i++) m_win[i] = '1;
            m_db = 2'b11; m_mask = '0; m_ec = '0; m_mode = '0; m_rd = '0;
        end else begin
            case (addr)
                3'd0:    m_rd = 32'(m_db);
                3'd1:    m_rd = 32'(s);
                3'd2:    m_rd = 32'(m_mask);
                3'd3:    m_rd = 32'(m_ec);
                3'd4:    m_rd = 32'(m_mode);
                default: m_rd = '0;
            endcase
            for (int i = 0; i < W; i++) begin
                m_win[i] = {m_win[i][DC-2:0], s[i]};
                if (m_win[i] == {DC{~m_db[i]}}) begin
                    m_db[i] = s[i];
                    md = m_mode[2*i +: 2];
                    hit[i] = (md == 2'b01 && s[i]) || (md == 2'b10 && !s[i]) || (md == 2'b11);
                end
            end
            if (cs && !wn && addr == 3'd3) w1c = wd[W-1:0];
            m_ec = (m_ec & ~w1c) | hit;
            if (cs && !wn && addr == 3'd2) m_mask = wd[W-1:0];
            if (cs && !wn && addr == 3'd4) m_mode = wd[2*W-1:0];
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = pin;
        end
        m_irq = |(m_ec & m_mask);
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic rst, input logic [W-1:0] pin, input logic [2:0] addr,
                        input logic cs, input logic wn, input logic [31:0] wd);
        reset          = rst;
        in_port        = pin;
        bus.address    = addr;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        model_edge(rst, pin, addr, cs, wn, wd);
        @(posedge clk);
        #1;
        check("readdata", bus.readdata, m_rd);
        check("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic rd_cyc(input logic [W-1:0] pin, input logic [2:0] addr);
        step(1'b0, pin, addr, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic wr_cyc(input logic [W-1:0] pin, input logic [2:0] addr, input logic [31:0] wd);
        step(1'b0, pin, addr, 1'b1, 1'b0, wd);
    endtask

    task automatic hold(input logic [W-1:0] pin, input int n);
        for (int k = 0; k < n; k++) rd_cyc(pin, 3'd0);
    endtask

    int first;
    int rises;
    logic prev_irq;
    logic [W-1:0] pin_r;
    logic [3:0]   bounce;

    initial begin
        // 1: reset with keys idle high
        for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 3'd0, 1'b0, 1'b1, 32'h0);
        check("t1_rst_readdata", bus.readdata, 32'h0);
        check("t1_rst_irq", 32'(bus.irq), 32'h0);
        rd_cyc(2'b11, 3'd0); check("t1_data", bus.readdata, 32'h3);
        rd_cyc(2'b11, 3'd2); check("t1_mask", bus.readdata, 32'h0);
        rd_cyc(2'b11, 3'd3); check("t1_capt", bus.readdata, 32'h0);
        rd_cyc(2'b11, 3'd4); check("t1_mode", bus.readdata, 32'h0);

        // 2: falling edge on bit0 with latency SS+DC
        wr_cyc(2'b11, 3'd4, 32'h2);
        wr_cyc(2'b11, 3'd2, 32'h1);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            rd_cyc(2'b10, 3'd0);
            if (bus.irq && first == 0) first = k;
        end
        check("t2_latency", first, 6);
        check("t2_data", bus.readdata, 32'h2);
        rd_cyc(2'b10, 3'd3); check("t2_capt", bus.readdata, 32'h1);
        wr_cyc(2'b10, 3'd3, 32'h1); check("t2_w1c_irq", 32'(bus.irq), 32'h0);

        // 3: bounce on bit0 after releasing it; exactly one capture
        hold(2'b11, 10);
        bounce   = 4'b0;
        first    = 0;
        rises    = 0;
        prev_irq = bus.irq;
        for (int k = 1; k <= 16; k++) begin
            pin_r = (k == 4) ? 2'b11 : 2'b10;
            rd_cyc(pin_r, 3'd1);
            if (bus.irq && !prev_irq) begin
                rises++;
                if (first == 0) first = k;
            end
            prev_irq = bus.irq;
        end
        check("t3_captures", rises, 1);
        check("t3_commit", first, 10);
        wr_cyc(2'b10, 3'd3, 32'h3);

        // 4: any-edge on bit1 with irq masked off
        wr_cyc(2'b10, 3'd4, 32'hE);
        wr_cyc(2'b10, 3'd2, 32'h0);
        hold(2'b00, 10);
        rd_cyc(2'b00, 3'd3); check("t4_press_capt", bus.readdata, 32'h2);
        check("t4_press_irq", 32'(bus.irq), 32'h0);
        wr_cyc(2'b00, 3'd3, 32'h2);
        hold(2'b10, 10);
        rd_cyc(2'b10, 3'd3); check("t4_release_capt", bus.readdata, 32'h2);
        check("t4_release_irq", 32'(bus.irq), 32'h0);
        wr_cyc(2'b10, 3'd2, 32'h2); check("t4_unmask_irq", 32'(bus.irq), 32'h1);

        // 5: W1C on the same edge as a falling commit on bit0
        wr_cyc(2'b10, 3'd3, 32'h3);
        hold(2'b11, 10);
        wr_cyc(2'b11, 3'd3, 32'h3);
        hold(2'b10, 5);
        wr_cyc(2'b10, 3'd3, 32'h1);
        rd_cyc(2'b10, 3'd3); check("t5_capt_kept", bus.readdata & 32'h1, 32'h1);

        // 6: reset in mid-debounce discards the count and generates no edge
        wr_cyc(2'b10, 3'd3, 32'h3);
        hold(2'b11, 10);
        hold(2'b10, 4);
        step(1'b1, 2'b10, 3'd0, 1'b0, 1'b1, 32'h0);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            rd_cyc(2'b10, 3'd0);
            if (k == 1) check("t6_data_after_rst", bus.readdata, 32'h3);
            if (!bus.readdata[0] && first == 0) first = k;
        end
        check("t6_fall_seen", first, 7);
        rd_cyc(2'b10, 3'd3); check("t6_capt", bus.readdata, 32'h0);

        // Randomised traffic against the model
        pin_r = 2'b10;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(5) == 0) pin_r = W'($urandom);
            if ($urandom_range(250) == 0)
                step(1'b1, pin_r, 3'd0, 1'b0, 1'b1, 32'h0);
            else
                step(1'b0, pin_r, 3'($urandom), 1'($urandom),
                     ($urandom_range(3) != 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
